// File: rtl/oam_scan_pkg.sv
// oam_scan_pkg: shared OAM constants, scan states and the sprite visibility test
package oam_scan_pkg;
    localparam int OAM_ENTRIES = 40;
    localparam int MAX_SPRITES = 10;
    typedef enum logic [1:0] {SCAN_IDLE, SCAN_RUN, SCAN_DRAIN} scan_state_e;
    // 9-bit compare so ly+16 and y+h never wrap
    function automatic logic sprite_visible(input logic [7:0] ly, input logic [7:0] y, input logic tall);
        logic [8:0] line, top, bot;
        line = {1'b0, ly} + 9'd16;
        top = {1'b0, y};
        bot = top + (tall ? 9'd16 : 9'd8);
        return line >= top && line < bot;
    endfunction
endpackage

// File: rtl/oam_scan_if.sv
// oam_scan_if: control, OAM read port and sprite buffer read port of the sprite search
interface oam_scan_if;
    logic start, obj_tall, dma_active, oam_re, busy, done;
    logic [7:0] ly, oam_addr, oam_data, rd_y, rd_x, rd_tile, rd_attr;
    logic [3:0] sprite_count, rd_idx;
    modport master (
        output start, ly, obj_tall, dma_active, oam_data, rd_idx,
        input oam_addr, oam_re, busy, done, sprite_count, rd_y, rd_x, rd_tile, rd_attr
    );
    modport slave (
        input start, ly, obj_tall, dma_active, oam_data, rd_idx,
        output oam_addr, oam_re, busy, done, sprite_count, rd_y, rd_x, rd_tile, rd_attr
    );
endinterface

// File: rtl/oam_sprite_buf.sv
// oam_sprite_buf: sprite slot register file, byte-lane write port and combinational word read
module oam_sprite_buf
    import oam_scan_pkg::*;
#(
    parameter int DEPTH = MAX_SPRITES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [3:0]  wr_slot,
    input  logic [1:0]  wr_lane,
    input  logic [7:0]  wr_data,
    input  logic [3:0]  rd_idx,
    output logic [31:0] rd_data
);
    logic [31:0] mem_q [DEPTH];
    logic [31:0] mem_d [DEPTH];
    always_comb begin
        mem_d = mem_q;
        if (we && wr_slot < 4'(DEPTH)) mem_d[wr_slot][wr_lane*8 +: 8] = wr_data;
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        else mem_q <= mem_d;
    assign rd_data = rd_idx < 4'(DEPTH) ? mem_q[rd_idx] : '0;
endmodule

// File: rtl/oam_scan.sv
// oam_scan: per-scanline walk of all OAM entries, keeping the first visible sprites in OAM order
module oam_scan #(
    parameter int MAX_SPRITES = oam_scan_pkg::MAX_SPRITES,
    parameter int OAM_ENTRIES = oam_scan_pkg::OAM_ENTRIES
) (
    input logic clock,
    input logic reset,
    oam_scan_if.slave bus
);
    import oam_scan_pkg::*;
    localparam logic [7:0] LAST = 8'(OAM_ENTRIES*4 - 1);
    localparam logic [3:0] CAP = 4'(MAX_SPRITES);
    scan_state_e state_q, state_d;
    logic [7:0] addr_q, addr_d, cap_addr_q, ly_q, ly_d, byte_c;
    logic [3:0] count_q, count_d;
    logic cap_v_q, cap_v_d, tall_q, tall_d, hit_q, hit_d, done_q, done_d, vis, we;
    logic [1:0] lane;
    logic [31:0] rd_word;
    always_comb begin
        // a byte read while DMA owns OAM is unreliable; 0xFF as Y can never match
        byte_c = bus.dma_active ? 8'hFF : bus.oam_data;
        lane = cap_addr_q[1:0];
        vis = sprite_visible(ly_q, byte_c, tall_q) && count_q < CAP;
        we = cap_v_q && !bus.start && (lane == 2'd0 ? vis : hit_q);
        hit_d = (cap_v_q && lane == 2'd0) ? vis : hit_q;
        cap_v_d = state_q == SCAN_RUN && !bus.start;
        count_d = count_q + 4'(we && lane == 2'd3);
        state_d = state_q;
        addr_d = addr_q;
        ly_d = ly_q;
        tall_d = tall_q;
        done_d = 1'b0;
        if (bus.start) begin
            state_d = SCAN_RUN;
            addr_d = '0;
            count_d = '0;
            ly_d = bus.ly;
            tall_d = bus.obj_tall;
        end else if (state_q == SCAN_RUN) begin
            state_d = addr_q == LAST ? SCAN_DRAIN : SCAN_RUN;
            addr_d = addr_q == LAST ? addr_q : addr_q + 8'd1;
        end else if (state_q == SCAN_DRAIN) begin
            state_d = SCAN_IDLE;
            done_d = 1'b1;
        end
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state_q <= SCAN_IDLE;
            addr_q <= '0;
            cap_addr_q <= '0;
            ly_q <= '0;
            count_q <= '0;
            cap_v_q <= 1'b0;
            tall_q <= 1'b0;
            hit_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            cap_addr_q <= addr_q;
            ly_q <= ly_d;
            count_q <= count_d;
            cap_v_q <= cap_v_d;
            tall_q <= tall_d;
            hit_q <= hit_d;
            done_q <= done_d;
        end
    oam_sprite_buf #(.DEPTH(MAX_SPRITES)) u_buf (
        .clock(clock), .reset(reset), .we(we), .wr_slot(count_q), .wr_lane(lane),
        .wr_data(byte_c), .rd_idx(bus.rd_idx), .rd_data(rd_word)
    );
    assign {bus.rd_attr, bus.rd_tile, bus.rd_x, bus.rd_y} = rd_word;
    assign bus.oam_addr = addr_q;
    assign bus.oam_re = state_q == SCAN_RUN;
    assign bus.busy = state_q != SCAN_IDLE;
    assign bus.done = done_q;
    assign bus.sprite_count = count_q;
endmodule

// File: tb/tb_oam_scan.sv
// tb_oam_scan: directed checks of the sprite search against hand-computed results
module tb_oam_scan;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [7:0] oam [160];
    int n_cmp = 0, n_bad = 0, seen = 0;
    int done_at, addr0, busy0, re160, busy160, busy_done, done_after;
    oam_scan_if bus();
    oam_scan dut (.clock(clock), .reset(reset), .bus(bus.slave));
    always #5 clock = ~clock;
    always @(posedge clock) if (bus.oam_re) bus.oam_data <= oam[bus.oam_addr];
    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic clear_oam();
        for (int i = 0; i < 160; i++) oam[i] = 8'h00;
    endtask
    task automatic fill(input logic [7:0] y);
        for (int e = 0; e < 40; e++) begin
            oam[4*e] = y;
            oam[4*e+1] = 8'(e);
            oam[4*e+2] = 8'(e + 128);
            oam[4*e+3] = 8'(e + 1);
        end
    endtask
    task automatic check_slot(input int i, input int y, input int x, input int t, input int a);
        bus.rd_idx = 4'(i);
        #1;
        check($sformatf("slot%0d_y", i), int'(bus.rd_y), y);
        check($sformatf("slot%0d_x", i), int'(bus.rd_x), x);
        check($sformatf("slot%0d_tile", i), int'(bus.rd_tile), t);
        check($sformatf("slot%0d_attr", i), int'(bus.rd_attr), a);
    endtask
    task automatic run_scan(input logic [7:0] ly, input logic tall, input int dlo, input int dhi);
        @(negedge clock);
        bus.ly = ly;
        bus.obj_tall = tall;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        done_at = -1;
        for (int n = 0; n < 200 && done_at < 0; n++) begin
            bus.dma_active = n >= dlo && n <= dhi;
            if (n == 0) begin addr0 = bus.oam_addr; busy0 = bus.busy; end
            if (n == 160) begin re160 = bus.oam_re; busy160 = bus.busy; end
            if (bus.done) begin done_at = n; busy_done = bus.busy; end
            else @(negedge clock);
        end
        bus.dma_active = 1'b0;
        @(negedge clock);
        done_after = bus.done;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
    initial begin
        bus.start = 1'b0;
        bus.ly = '0;
        bus.obj_tall = 1'b0;
        bus.dma_active = 1'b0;
        bus.rd_idx = '0;
        clear_oam();
        repeat (2) @(negedge clock);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_re", bus.oam_re, 0);
        check("rst_addr", bus.oam_addr, 0);
        check("rst_count", bus.sprite_count, 0);
        check("rst_slot0", {bus.rd_attr, bus.rd_tile, bus.rd_x, bus.rd_y}, 0);
        @(negedge clock);
        reset = 1'b0;
        run_scan(8'd0, 1'b0, -1, -1);
        check("zero_count", bus.sprite_count, 0);
        check("zero_done_at", done_at, 161);
        check("cyc0_addr", addr0, 0);
        check("cyc0_busy", busy0, 1);
        check("cyc160_re", re160, 0);
        check("cyc160_busy", busy160, 1);
        check("done_busy", busy_done, 0);
        check("done_pulse", done_after, 0);
        oam[20] = 8'd16; oam[21] = 8'd8; oam[22] = 8'h42; oam[23] = 8'h20;
        run_scan(8'd0, 1'b0, -1, -1);
        check("e5_count", bus.sprite_count, 1);
        check_slot(0, 16, 8, 'h42, 'h20);
        bus.rd_idx = 4'd10;
        #1;
        check("oob_slot", {bus.rd_attr, bus.rd_tile, bus.rd_x, bus.rd_y}, 0);
        fill(8'd20);
        run_scan(8'd10, 1'b1, -1, -1);
        check("tall_count", bus.sprite_count, 10);
        check_slot(0, 20, 0, 128, 1);
        check_slot(9, 20, 9, 137, 10);
        run_scan(8'd3, 1'b0, -1, -1);
        check("short_count", bus.sprite_count, 0);
        clear_oam();
        oam[0] = 8'd16;
        run_scan(8'd7, 1'b0, -1, -1);
        check("y16_ly7", bus.sprite_count, 1);
        run_scan(8'd8, 1'b0, -1, -1);
        check("y16_ly8", bus.sprite_count, 0);
        run_scan(8'd15, 1'b1, -1, -1);
        check("y16_ly15_tall", bus.sprite_count, 1);
        oam[0] = 8'd160;
        run_scan(8'd144, 1'b0, -1, -1);
        check("y160_ly144", bus.sprite_count, 1);
        run_scan(8'd143, 1'b0, -1, -1);
        check("y160_ly143", bus.sprite_count, 0);
        fill(8'd20);
        run_scan(8'd10, 1'b1, 1, 80);
        check("dma_count", bus.sprite_count, 10);
        check_slot(0, 20, 20, 148, 21);
        check_slot(9, 20, 29, 157, 30);
        @(negedge clock);
        bus.ly = 8'd10;
        bus.obj_tall = 1'b1;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        for (int n = 0; n < 50; n++) begin
            seen += int'(bus.done);
            @(negedge clock);
        end
        check("abort_no_done", seen, 0);
        check("abort_mid_count", bus.sprite_count, 10);
        run_scan(8'd3, 1'b0, -1, -1);
        check("restart_addr0", addr0, 0);
        check("restart_done_at", done_at, 161);
        check("restart_count", bus.sprite_count, 0);
        @(negedge clock);
        bus.ly = 8'd10;
        bus.obj_tall = 1'b1;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (70) @(negedge clock);
        check("pre_rst_count", bus.sprite_count, 10);
        reset = 1'b1;
        bus.rd_idx = 4'd0;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_count", bus.sprite_count, 0);
        check("mid_rst_re", bus.oam_re, 0);
        check("mid_rst_slot0", {bus.rd_attr, bus.rd_tile, bus.rd_x, bus.rd_y}, 0);
        @(negedge clock);
        reset = 1'b0;
        run_scan(8'd10, 1'b1, -1, -1);
        check("post_rst_count", bus.sprite_count, 10);
        check("post_rst_done_at", done_at, 161);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
